lcd_win_ctrl: RTL and testbench

LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

---
 rtl/lcd_win_pkg.sv | 55 +++++
 rtl/lcd_win_alu.sv | 81 ++++++++
 rtl/lcd_win_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_win_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_win_pkg.sv
// Shared definitions for the LCD window controller: command codes, FSM state
// encoding and the window arithmetic helpers used by lcd_win_alu.
package lcd_win_pkg;

  // Widest pixel the helper functions handle; callers zero-extend to this width.
  localparam int unsigned MAX_DW = 16;

  localparam logic [3:0] CmdWrite  = 4'd0;
  localparam logic [3:0] CmdUp     = 4'd1;
  localparam logic [3:0] CmdDown   = 4'd2;
  localparam logic [3:0] CmdLeft   = 4'd3;
  localparam logic [3:0] CmdRight  = 4'd4;
  localparam logic [3:0] CmdMax    = 4'd5;
  localparam logic [3:0] CmdMin    = 4'd6;
  localparam logic [3:0] CmdAvg    = 4'd7;
  localparam logic [3:0] CmdRotCcw = 4'd8;
  localparam logic [3:0] CmdRotCw  = 4'd9;
  localparam logic [3:0] CmdMirX   = 4'd10;
  localparam logic [3:0] CmdMirY   = 4'd11;
  localparam logic [3:0] CmdOrigin = 4'd12;
  localparam logic [3:0] CmdMedian = 4'd13;

  typedef enum logic [2:0] {
    StLoad,
    StCmd,
    StExec,
    StWrite,
    StDone
  } state_e;

  function automatic logic [MAX_DW-1:0] max4(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b,
                                              input logic [MAX_DW-1:0] c, input logic [MAX_DW-1:0] d);
    logic [MAX_DW-1:0] ab, cd;
    ab = (a > b) ? a : b;
    cd = (c > d) ? c : d;
    return (ab > cd) ? ab : cd;
  endfunction

  function automatic logic [MAX_DW-1:0] min4(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b,
                                              input logic [MAX_DW-1:0] c, input logic [MAX_DW-1:0] d);
    logic [MAX_DW-1:0] ab, cd;
    ab = (a < b) ? a : b;
    cd = (c < d) ? c : d;
    return (ab < cd) ? ab : cd;
  endfunction

  // Two guard bits keep the four-way sum from overflowing.
  function automatic logic [MAX_DW-1:0] avg4(input logic [MAX_DW-1:0] a, input logic [MAX_DW-1:0] b,
                                              input logic [MAX_DW-1:0] c, input logic [MAX_DW-1:0] d);
    logic [MAX_DW+1:0] s;
    s = (MAX_DW+2)'(a) + (MAX_DW+2)'(b) + (MAX_DW+2)'(c) + (MAX_DW+2)'(d);
    return s[MAX_DW+1:2];
  endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window arithmetic. Pixel order: p0 top-left, p1 top-right,
// p2 bottom-left, p3 bottom-right. Commands that do not touch the image pass
// the window through unchanged. DATA_W must not exceed MAX_DW.
// Optional feature: define LCD_WIN_CTRL_MEDIAN_EN to enable the cmd 13 median.
module lcd_win_alu
  import lcd_win_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_p0,
  input  logic [DATA_W-1:0] i_p1,
  input  logic [DATA_W-1:0] i_p2,
  input  logic [DATA_W-1:0] i_p3,
  output logic [DATA_W-1:0] o_q0,
  output logic [DATA_W-1:0] o_q1,
  output logic [DATA_W-1:0] o_q2,
  output logic [DATA_W-1:0] o_q3
);

  logic [MAX_DW-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [DATA_W-1:0] w_max, w_min, w_avg;

  assign w_a0 = MAX_DW'(i_p0);
  assign w_a1 = MAX_DW'(i_p1);
  assign w_a2 = MAX_DW'(i_p2);
  assign w_a3 = MAX_DW'(i_p3);

  assign w_max = DATA_W'(max4(w_a0, w_a1, w_a2, w_a3));
  assign w_min = DATA_W'(min4(w_a0, w_a1, w_a2, w_a3));
  assign w_avg = DATA_W'(avg4(w_a0, w_a1, w_a2, w_a3));

`ifdef LCD_WIN_CTRL_MEDIAN_EN
  // Sum of the two middle values = total minus the extremes.
  logic [MAX_DW+1:0] w_sum, w_mid2;
  logic [DATA_W-1:0] w_med;

  assign w_sum  = (MAX_DW+2)'(w_a0) + (MAX_DW+2)'(w_a1) + (MAX_DW+2)'(w_a2) + (MAX_DW+2)'(w_a3);
  assign w_mid2 = w_sum - (MAX_DW+2)'(max4(w_a0, w_a1, w_a2, w_a3))
                        - (MAX_DW+2)'(min4(w_a0, w_a1, w_a2, w_a3));
  assign w_med  = DATA_W'(w_mid2 >> 1);
`endif

  // Select the new window contents for the current command.
  always_comb begin
    o_q0 = i_p0;
    o_q1 = i_p1;
    o_q2 = i_p2;
    o_q3 = i_p3;
    case (i_cmd)
      CmdMax: begin
        o_q0 = w_max; o_q1 = w_max; o_q2 = w_max; o_q3 = w_max;
      end
      CmdMin: begin
        o_q0 = w_min; o_q1 = w_min; o_q2 = w_min; o_q3 = w_min;
      end
      CmdAvg: begin
        o_q0 = w_avg; o_q1 = w_avg; o_q2 = w_avg; o_q3 = w_avg;
      end
      CmdRotCcw: begin
        o_q0 = i_p1; o_q1 = i_p3; o_q2 = i_p0; o_q3 = i_p2;
      end
      CmdRotCw: begin
        o_q0 = i_p2; o_q1 = i_p0; o_q2 = i_p3; o_q3 = i_p1;
      end
      CmdMirX: begin
        o_q0 = i_p2; o_q1 = i_p3; o_q2 = i_p0; o_q3 = i_p1;
      end
      CmdMirY: begin
        o_q0 = i_p1; o_q1 = i_p0; o_q2 = i_p3; o_q3 = i_p2;
      end
`ifdef LCD_WIN_CTRL_MEDIAN_EN
      CmdMedian: begin
        o_q0 = w_med; o_q1 = w_med; o_q2 = w_med; o_q3 = w_med;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads an IMG_W x IMG_W image from ROM, applies 2x2
// window commands around a movable operation point, then streams the image
// out to RAM. Optional feature macro: LCD_WIN_CTRL_MEDIAN_EN (cmd 13 median).
module lcd_win_ctrl
  import lcd_win_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned LW    = $clog2(IMG_W),
  localparam int unsigned AW    = 2 * LW,
  localparam int unsigned NPIX  = IMG_W * IMG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] IROM_Q,
  output logic              IROM_rd,
  output logic [AW-1:0]     IROM_A,
  output logic              IRAM_valid,
  output logic [DATA_W-1:0] IRAM_D,
  output logic [AW-1:0]     IRAM_A,
  output logic              busy,
  output logic              done
);

  localparam logic [LW-1:0] PtMid    = LW'(IMG_W / 2);
  localparam logic [LW-1:0] PtMax    = LW'(IMG_W - 1);
  localparam logic [LW-1:0] PtMin    = LW'(1);
  localparam logic [AW:0]   CntFull  = (AW+1)'(NPIX);
  localparam logic [AW:0]   CntLast  = (AW+1)'(NPIX - 1);

  state_e            r_state, w_state_nxt;
  logic [AW:0]       r_cnt, w_cnt_nxt;
  logic [LW-1:0]     r_x, r_y, w_x_nxt, w_y_nxt;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_mem [NPIX];

  logic [LW-1:0]     w_xm1, w_ym1;
  logic [AW-1:0]     w_a_tl, w_a_tr, w_a_bl, w_a_br, w_cap_addr, w_cnt_addr;
  logic [DATA_W-1:0] w_q0, w_q1, w_q2, w_q3;

  // Row-major address is just {row, col} because IMG_W is a power of two.
  assign w_xm1      = r_x - PtMin;
  assign w_ym1      = r_y - PtMin;
  assign w_a_tl     = {w_ym1, w_xm1};
  assign w_a_tr     = {w_ym1, r_x};
  assign w_a_bl     = {r_y, w_xm1};
  assign w_a_br     = {r_y, r_x};
  assign w_cnt_addr = r_cnt[AW-1:0];
  // ROM data lags the address by one cycle, so capture lands one slot behind.
  assign w_cap_addr = AW'(r_cnt - (AW+1)'(1));

  lcd_win_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_cmd(r_cmd),
    .i_p0 (r_mem[w_a_tl]),
    .i_p1 (r_mem[w_a_tr]),
    .i_p2 (r_mem[w_a_bl]),
    .i_p3 (r_mem[w_a_br]),
    .o_q0 (w_q0),
    .o_q1 (w_q1),
    .o_q2 (w_q2),
    .o_q3 (w_q3)
  );

  // State, counter, operation point and latched command.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StLoad;
      r_cnt   <= '0;
      r_x     <= PtMid;
      r_y     <= PtMid;
      r_cmd   <= CmdWrite;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      if (r_state == StCmd && cmd_valid) r_cmd <= cmd;
    end
  end

  // Pixel storage: filled during LOAD, window rewritten in EXEC; never cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == StLoad && r_cnt != '0) r_mem[w_cap_addr] <= IROM_Q;
      if (r_state == StExec) begin
        r_mem[w_a_tl] <= w_q0;
        r_mem[w_a_tr] <= w_q1;
        r_mem[w_a_bl] <= w_q2;
        r_mem[w_a_br] <= w_q3;
      end
    end
  end

  // Next-state logic: sequencing, counter and point movement.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    case (r_state)
      StLoad: begin
        if (r_cnt == CntFull) begin
          w_state_nxt = StCmd;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + (AW+1)'(1);
        end
      end
      StCmd: begin
        if (cmd_valid) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (cmd == CmdWrite) ? StWrite : StExec;
        end
      end
      StExec: begin
        w_state_nxt = StCmd;
        case (r_cmd)
          CmdUp:     if (r_y > PtMin) w_y_nxt = r_y - PtMin;
          CmdDown:   if (r_y < PtMax) w_y_nxt = r_y + PtMin;
          CmdLeft:   if (r_x > PtMin) w_x_nxt = r_x - PtMin;
          CmdRight:  if (r_x < PtMax) w_x_nxt = r_x + PtMin;
          CmdOrigin: begin
            w_x_nxt = PtMid;
            w_y_nxt = PtMid;
          end
          default: ;
        endcase
      end
      StWrite: begin
        if (r_cnt == CntLast) begin
          w_state_nxt = StDone;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + (AW+1)'(1);
        end
      end
      StDone: ;
      default: w_state_nxt = StLoad;
    endcase
  end

  // Moore outputs decoded from state and counter.
  always_comb begin
    IROM_rd    = 1'b0;
    IROM_A     = '0;
    IRAM_valid = 1'b0;
    IRAM_A     = '0;
    IRAM_D     = '0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      StLoad: begin
        IROM_rd = 1'b1;
        IROM_A  = w_cnt_addr;
      end
      StCmd:  busy = 1'b0;
      StWrite: begin
        IRAM_valid = 1'b1;
        IRAM_A     = w_cnt_addr;
        IRAM_D     = r_mem[w_cnt_addr];
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Directed bench for lcd_win_ctrl: table of command sequences on an 8x8/8-bit
// instance, plus hand sequences for reset, timing and a 16x16/10-bit instance.
module tb_lcd_win_ctrl;

  typedef struct packed {
    logic [1:0]       pat;
    logic [3:0]       ncmd;
    logic [47:0]      cmds;   // nibble i = i-th command
    logic [3:0][7:0]  addr;   // [3]=TL [2]=TR [1]=BL [0]=BR
    logic [3:0][7:0]  expv;
  } vec_t;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance
  logic       reset, cmd_valid;
  logic [3:0] cmd;
  logic [7:0] rom_q, IRAM_D;
  logic [5:0] IROM_A, IRAM_A;
  logic       IROM_rd, IRAM_valid, busy, done;

  // 16x16, 10-bit instance
  logic       reset2, cmd_valid2;
  logic [3:0] cmd2;
  logic [9:0] rom_q2, IRAM_D2;
  logic [7:0] IROM_A2, IRAM_A2;
  logic       IROM_rd2, IRAM_valid2, busy2, done2;

  logic [7:0] rom [64];
  logic [7:0] ram [64];
  int         wr_cnt, wr_order_err, cnt2, bad2;
  logic       wr_clr, clr2;
  int         n_cmp = 0, n_bad = 0;
  vec_t       vecs [12];

  assign rom_q2 = 10'd1023;

  lcd_win_ctrl #(.IMG_W(8), .DATA_W(8)) u_dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(rom_q),
    .IROM_rd(IROM_rd), .IROM_A(IROM_A), .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D),
    .IRAM_A(IRAM_A), .busy(busy), .done(done)
  );

  lcd_win_ctrl #(.IMG_W(16), .DATA_W(10)) u_dut16 (
    .clk(clk), .reset(reset2), .cmd(cmd2), .cmd_valid(cmd_valid2), .IROM_Q(rom_q2),
    .IROM_rd(IROM_rd2), .IROM_A(IROM_A2), .IRAM_valid(IRAM_valid2), .IRAM_D(IRAM_D2),
    .IRAM_A(IRAM_A2), .busy(busy2), .done(done2)
  );

  // ROM model: data one cycle after address.
  always @(posedge clk) rom_q <= rom[IROM_A];

  // RAM model with write tally and address-order check.
  always @(posedge clk) begin
    if (wr_clr) begin
      wr_cnt       <= 0;
      wr_order_err <= 0;
    end else if (IRAM_valid) begin
      ram[IRAM_A] <= IRAM_D;
      if (int'(IRAM_A) != wr_cnt) wr_order_err <= wr_order_err + 1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (clr2) begin
      cnt2 <= 0;
      bad2 <= 0;
    end else if (IRAM_valid2) begin
      if (IRAM_D2 != 10'd1023 || int'(IRAM_A2) != cnt2) bad2 <= bad2 + 1;
      cnt2 <= cnt2 + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int pat, input int n, input logic [47:0] c,
                              input int a0, input int a1, input int a2, input int a3,
                              input int e0, input int e1, input int e2, input int e3);
    vec_t v;
    v.pat  = 2'(pat);
    v.ncmd = 4'(n);
    v.cmds = c;
    v.addr = {8'(a0), 8'(a1), 8'(a2), 8'(a3)};
    v.expv = {8'(e0), 8'(e1), 8'(e2), 8'(e3)};
    return v;
  endfunction

  task automatic load_pat(input int p);
    for (int k = 0; k < 64; k++) rom[k] = 8'(k);
    if (p == 1) begin
      rom[27] = 8'd10; rom[28] = 8'd20; rom[35] = 8'd30; rom[36] = 8'd40;
    end else if (p == 2) begin
      rom[27] = 8'd5; rom[28] = 8'd9; rom[35] = 8'd1; rom[36] = 8'd200;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    wr_clr    = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    wr_clr = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic send_cmd(input logic [3:0] c);
    int n;
    wait_idle("cmd_wait", n);
    cmd       = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk({nm, "_done_timeout"}, 1, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n, err;
    logic inwin;
    load_pat(int'(v.pat));
    do_reset();
    wait_idle("load", n);
    for (int i = 0; i < int'(v.ncmd); i++) send_cmd(v.cmds[4*i +: 4]);
    send_cmd(4'd0);
    wait_done($sformatf("v%0d", idx));
    for (int j = 0; j < 4; j++)
      chk($sformatf("v%0d_win%0d", idx, j), int'(ram[v.addr[j][5:0]]), int'(v.expv[j]));
    err = 0;
    for (int a = 0; a < 64; a++) begin
      inwin = 1'b0;
      for (int j = 0; j < 4; j++) if (int'(v.addr[j]) == a) inwin = 1'b1;
      if (!inwin && ram[a] !== rom[a]) err++;
    end
    chk($sformatf("v%0d_rest", idx), err, 0);
    chk($sformatf("v%0d_wr_cnt", idx), wr_cnt, 64);
    chk($sformatf("v%0d_wr_order", idx), wr_order_err, 0);
  endtask

  initial begin
    int n, aerr;
    reset = 1'b1; cmd = 4'd0; cmd_valid = 1'b0; wr_clr = 1'b1;
    reset2 = 1'b1; cmd2 = 4'd0; cmd_valid2 = 1'b0; clr2 = 1'b1;

    vecs[0]  = mk(0, 1,  48'h5,           27, 28, 35, 36, 36, 36, 36, 36);
    vecs[1]  = mk(0, 11, 48'h71111111111,  3,  4, 11, 12,  7,  7,  7,  7);
    vecs[2]  = mk(1, 1,  48'h9,           27, 28, 35, 36, 30, 10, 40, 20);
    vecs[3]  = mk(1, 2,  48'hA9,          27, 28, 35, 36, 40, 20, 30, 10);
    vecs[4]  = mk(1, 1,  48'h8,           27, 28, 35, 36, 20, 40, 10, 30);
    vecs[5]  = mk(1, 1,  48'hB,           27, 28, 35, 36, 20, 10, 40, 30);
    vecs[6]  = mk(1, 1,  48'h6,           27, 28, 35, 36, 10, 10, 10, 10);
`ifdef LCD_WIN_CTRL_MEDIAN_EN
    vecs[7]  = mk(2, 1,  48'hD,           27, 28, 35, 36,  7,  7,  7,  7);
`else
    vecs[7]  = mk(2, 1,  48'hD,           27, 28, 35, 36,  5,  9,  1, 200);
`endif
    vecs[8]  = mk(0, 6,  48'h744444,      30, 31, 38, 39, 34, 34, 34, 34);
    vecs[9]  = mk(0, 9,  48'h5C3322222,   27, 28, 35, 36, 36, 36, 36, 36);
    vecs[10] = mk(0, 2,  48'hFE,          27, 28, 35, 36, 27, 28, 35, 36);
    vecs[11] = mk(0, 9,  48'h633332222,   48, 49, 56, 57, 48, 48, 48, 48);

    // Reset state and LOAD timing.
    load_pat(0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_irom_rd", int'(IROM_rd), 1);
    chk("rst_irom_a", int'(IROM_A), 0);
    chk("rst_iram_valid", int'(IRAM_valid), 0);
    chk("rst_iram_a", int'(IRAM_A), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_done", int'(done), 0);
    reset = 1'b0; wr_clr = 1'b0;
    n = 0; aerr = 0;
    while (busy && n < 300) begin
      if (int'(IROM_A) != (n % 64) || !IROM_rd) aerr++;
      n++;
      @(negedge clk);
    end
    chk("load_cycles", n, 65);
    chk("load_addr_seq", aerr, 0);
    chk("cmd_irom_rd", int'(IROM_rd), 0);

    // EXEC lasts exactly one busy cycle.
    cmd = 4'd14; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_busy", int'(busy), 1);
    @(negedge clk);
    chk("exec_one_cycle", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("cmd_idle_stays", int'(busy), 0);

    // Plain write-out, then DONE ignores commands.
    send_cmd(4'd0);
    chk("write_first_valid", int'(IRAM_valid), 1);
    wait_done("plain");
    chk("plain_wr_cnt", wr_cnt, 64);
    cmd = 4'd0; cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    chk("done_hold", int'(done), 1);
    chk("done_busy", int'(busy), 1);
    chk("done_no_rewrite", wr_cnt, 64);
    aerr = 0;
    for (int a = 0; a < 64; a++) if (ram[a] !== 8'(a)) aerr++;
    chk("plain_image", aerr, 0);

    // Table-driven command vectors.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset mid-LOAD, then reset at WRITE cycle 20.
    load_pat(0);
    do_reset();
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midload_irom_a", int'(IROM_A), 0);
    chk("midload_irom_rd", int'(IROM_rd), 1);
    wait_idle("reload", n);
    chk("reload_cycles", n, 65);
    send_cmd(4'd0);
    n = 0;
    while (!(IRAM_valid && IRAM_A == 6'd20) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) chk("write20_timeout", 1, 0);
    reset = 1'b1; wr_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr_clr = 1'b0;
    chk("wrrst_iram_valid", int'(IRAM_valid), 0);
    chk("wrrst_irom_rd", int'(IROM_rd), 1);
    chk("wrrst_irom_a", int'(IROM_A), 0);
    chk("wrrst_busy", int'(busy), 1);
    chk("wrrst_done", int'(done), 0);
    wait_idle("reload2", n);
    send_cmd(4'd0);
    wait_done("after_rst");
    chk("after_rst_wr_cnt", wr_cnt, 64);
    aerr = 0;
    for (int a = 0; a < 64; a++) if (ram[a] !== 8'(a)) aerr++;
    chk("after_rst_image", aerr, 0);

    // 16x16, 10-bit: all-ones average must not overflow.
    reset2 = 1'b0; clr2 = 1'b0;
    chk("w16_rst_irom_rd", int'(IROM_rd2), 1);
    chk("w16_rst_irom_a", int'(IROM_A2), 0);
    n = 0;
    while (busy2 && n < 600) begin n++; @(negedge clk); end
    chk("w16_load_cycles", n, 257);
    cmd2 = 4'd7; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    @(negedge clk);
    cmd2 = 4'd0; cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    n = 0;
    while (!done2 && n < 600) begin n++; @(negedge clk); end
    if (n >= 600) chk("w16_done_timeout", 1, 0);
    chk("w16_wr_cnt", cnt2, 256);
    chk("w16_bad_pixels", bad2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
